// File: rtl/lime_ctrl_pkg.sv
// Shared encodings for the lime multi-cycle controller.
// Covers the state codes, opcode/funct fields, ALUOp values and trap causes.
package lime_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_RTYPE     = 4'd2,
    S_RITYPE    = 4'd3,
    S_RTYPE_END = 4'd4,
    S_LW1       = 4'd5,
    S_LW2       = 4'd6,
    S_SW        = 4'd7,
    S_JALR      = 4'd8,
    S_BRANCH    = 4'd9,
    S_BRANCH2   = 4'd10,
    S_JAL       = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [2:0] OPC_R   = 3'b000;
  localparam logic [2:0] OPC_RI  = 3'b001;
  localparam logic [2:0] OPC_I   = 3'b010;
  localparam logic [2:0] OPC_L   = 3'b011;
  localparam logic [2:0] OPC_JAL = 3'b100;

  localparam logic [3:0] FUNCT_LW      = 4'b1001;
  localparam logic [3:0] FUNCT_SW      = 4'b1010;
  localparam logic [3:0] FUNCT_JALR    = 4'b1011;
  localparam logic [3:0] FUNCT_BR_MASK = 4'b1100;
  localparam logic [3:0] FUNCT_R_MAX   = 4'b1000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_CMP  = 4'b1001;
  localparam logic [3:0] ALU_IDLE = 4'b1111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_LW1) || (s == S_SW);
  endfunction

endpackage

// File: rtl/lime_wait_timer.sv
// Memory wait-state watchdog: counts consecutive not-ready cycles in a waiting state
// and flags a timeout once WAIT_MAX of them have elapsed without completion.
module lime_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_ready,
  input  logic stall,
  output logic timeout
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);

  logic [CW-1:0] cnt;

  // A ready response in the same cycle always wins over the timeout.
  assign timeout = (WAIT_MAX != 0) && active && !mem_ready && (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!stall) begin
      if (!active || mem_ready || timeout) cnt <= '0;
      else                                 cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lime_control_fsm.sv
// Multi-cycle control FSM for lime: sequences fetch/decode/execute, handles memory
// wait-states, stalls, illegal-opcode and bus-timeout traps, and counts retirements.
module lime_control_fsm
  import lime_ctrl_pkg::*;
#(
  parameter int FUNCT_W  = 4,
  parameter int OPC_W    = 3,
  parameter int ALUOP_W  = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [FUNCT_W+OPC_W-1:0] input_control,
  input  logic                     mem_ready,
  input  logic                     stall,
  input  logic                     trap_clear,
  output logic                     output_control_Branch,
  output logic                     output_control_IoD,
  output logic                     output_control_IRWrite,
  output logic                     output_control_Mem2Reg,
  output logic                     output_control_MemR,
  output logic                     output_control_MemW,
  output logic                     output_control_PCSrc,
  output logic                     output_control_PCWrite,
  output logic                     output_control_RegWrite,
  output logic [1:0]               output_control_ALUSrcA,
  output logic [1:0]               output_control_ALUSrcB,
  output logic [1:0]               output_control_BranchType,
  output logic [ALUOP_W-1:0]       output_control_ALUOp,
  output logic                     output_control_trap,
  output logic [1:0]               output_control_trap_cause,
  output logic [CNT_W-1:0]         output_control_instret,
  output logic [3:0]               output_control_current_state,
  output logic [3:0]               output_control_next_state
);

  logic [OPC_W-1:0]   opc;
  logic [FUNCT_W-1:0] funct;
  state_t             state, nxt;
  logic [1:0]         cause, new_cause;
  logic [CNT_W-1:0]   instret;
  logic               timeout, retire, set_trap;

  assign opc   = input_control[OPC_W-1:0];
  assign funct = input_control[FUNCT_W+OPC_W-1:OPC_W];

  lime_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk       (CLK),
    .rst       (Reset),
    .active    (is_wait_state(state)),
    .mem_ready (mem_ready),
    .stall     (stall),
    .timeout   (timeout)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= S_FETCH;
      cause   <= CAUSE_NONE;
      instret <= '0;
    end else begin
      state <= nxt;
      if (set_trap) cause   <= new_cause;
      if (retire)   instret <= instret + 1'b1;
    end
  end

  always_comb begin
    nxt       = state;
    set_trap  = 1'b0;
    new_cause = CAUSE_NONE;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        if (timeout) begin
          nxt = S_TRAP; set_trap = 1'b1; new_cause = CAUSE_TIMEOUT;
        end else if (mem_ready) begin
          nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opc == OPC_W'(OPC_R)) begin
          nxt = S_RTYPE;
        end else if (opc == OPC_W'(OPC_RI)) begin
          if (funct == FUNCT_W'(FUNCT_JALR))
            nxt = S_JALR;
          else if ((funct & FUNCT_W'(FUNCT_BR_MASK)) == FUNCT_W'(FUNCT_BR_MASK))
            nxt = S_BRANCH;
          else
            nxt = S_RITYPE;
        end else if (opc == OPC_W'(OPC_I)) begin
          nxt = S_RITYPE;
        end else if (opc == OPC_W'(OPC_L)) begin
          nxt = S_FETCH; retire = 1'b1;
        end else if (opc == OPC_W'(OPC_JAL)) begin
          nxt = S_JAL;
        end else begin
          nxt = S_TRAP; set_trap = 1'b1; new_cause = CAUSE_ILLEGAL;
        end
      end
      S_RTYPE: begin
        if (funct > FUNCT_W'(FUNCT_R_MAX)) begin
          nxt = S_TRAP; set_trap = 1'b1; new_cause = CAUSE_ILLEGAL;
        end else begin
          nxt = S_RTYPE_END;
        end
      end
      S_RITYPE: begin
        if (funct == FUNCT_W'(FUNCT_LW))      nxt = S_LW1;
        else if (funct == FUNCT_W'(FUNCT_SW)) nxt = S_SW;
        else                                  nxt = S_RTYPE_END;
      end
      S_LW1: begin
        if (timeout) begin
          nxt = S_TRAP; set_trap = 1'b1; new_cause = CAUSE_TIMEOUT;
        end else if (mem_ready) begin
          nxt = S_LW2;
        end
      end
      S_SW: begin
        if (timeout) begin
          nxt = S_TRAP; set_trap = 1'b1; new_cause = CAUSE_TIMEOUT;
        end else if (mem_ready) begin
          nxt = S_FETCH; retire = 1'b1;
        end
      end
      S_RTYPE_END, S_LW2, S_JALR, S_JAL, S_BRANCH2: begin
        nxt = S_FETCH; retire = 1'b1;
      end
      S_BRANCH: nxt = S_BRANCH2;
      S_TRAP:   if (trap_clear) nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
    // A stall freezes the whole controller, overriding ready, timeout and trap_clear.
    if (stall) begin
      nxt      = state;
      set_trap = 1'b0;
      retire   = 1'b0;
    end
  end

  always_comb begin
    output_control_Branch     = 1'b0;
    output_control_IoD        = 1'b0;
    output_control_IRWrite    = 1'b0;
    output_control_Mem2Reg    = 1'b0;
    output_control_MemR       = 1'b0;
    output_control_MemW       = 1'b0;
    output_control_PCSrc      = 1'b0;
    output_control_PCWrite    = 1'b0;
    output_control_RegWrite   = 1'b0;
    output_control_ALUSrcA    = 2'd0;
    output_control_ALUSrcB    = 2'd0;
    output_control_BranchType = 2'd0;
    output_control_ALUOp      = ALUOP_W'(ALU_IDLE);
    case (state)
      S_FETCH: begin
        output_control_MemR    = 1'b1;
        output_control_ALUSrcB = 2'd1;
        output_control_ALUOp   = ALUOP_W'(ALU_ADD);
        output_control_IRWrite = mem_ready;
        output_control_PCWrite = mem_ready;
      end
      S_RTYPE: begin
        output_control_ALUSrcA = 2'd2;
        output_control_ALUOp   = ALUOP_W'(funct);
      end
      S_RITYPE: begin
        output_control_ALUSrcA = 2'd2;
        output_control_ALUSrcB = 2'd2;
        if (funct == FUNCT_W'(FUNCT_LW) || funct == FUNCT_W'(FUNCT_SW))
          output_control_ALUOp = ALUOP_W'(ALU_ADD);
        else
          output_control_ALUOp = ALUOP_W'(funct);
      end
      S_RTYPE_END: output_control_RegWrite = 1'b1;
      S_LW1: begin
        output_control_IoD  = 1'b1;
        output_control_MemR = 1'b1;
      end
      S_LW2: begin
        output_control_RegWrite = 1'b1;
        output_control_Mem2Reg  = 1'b1;
      end
      S_SW: begin
        output_control_IoD  = 1'b1;
        output_control_MemW = 1'b1;
      end
      S_JALR, S_JAL: begin
        output_control_ALUSrcA  = 2'd3;
        output_control_ALUSrcB  = 2'd1;
        output_control_ALUOp    = ALUOP_W'(ALU_PASS);
        output_control_RegWrite = (state == S_JALR);
        output_control_PCWrite  = (state == S_JAL);
      end
      S_BRANCH: begin
        output_control_ALUOp      = ALUOP_W'(ALU_CMP);
        output_control_ALUSrcB    = 2'd2;
        output_control_Branch     = 1'b1;
        output_control_BranchType = funct[1:0];
      end
      S_BRANCH2: begin
        output_control_ALUOp      = ALUOP_W'(ALU_SUB);
        output_control_ALUSrcA    = 2'd2;
        output_control_Branch     = 1'b1;
        output_control_BranchType = funct[1:0];
        output_control_PCSrc      = 1'b1;
        output_control_PCWrite    = 1'b1;
      end
      default: ;
    endcase
    // Stall only blocks state-changing writes; read and mux selects stay live.
    if (stall) begin
      output_control_PCWrite  = 1'b0;
      output_control_IRWrite  = 1'b0;
      output_control_RegWrite = 1'b0;
      output_control_MemW     = 1'b0;
    end
  end

  assign output_control_trap          = (state == S_TRAP);
  assign output_control_trap_cause    = cause;
  assign output_control_instret       = instret;
  assign output_control_current_state = state;
  assign output_control_next_state    = nxt;

endmodule

// File: tb/tb_lime_control_fsm.sv
// Directed bench for lime_control_fsm with hand-computed expectations per cycle.
module tb_lime_control_fsm;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             Reset;
  logic [6:0]       input_control;
  logic             mem_ready, stall, trap_clear;
  logic             br, iod, irw, m2r, memr, memw, pcsrc, pcw, regw, trap;
  logic [1:0]       srca, srcb, btype, cause;
  logic [3:0]       aluop, st, nst;
  logic [CNT_W-1:0] instret;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_ir   = '0;

  always #5 CLK = ~CLK;

  lime_control_fsm #(
    .FUNCT_W(4), .OPC_W(3), .ALUOP_W(4), .WAIT_MAX(15), .CNT_W(CNT_W)
  ) dut (
    .CLK                          (CLK),
    .Reset                        (Reset),
    .input_control                (input_control),
    .mem_ready                    (mem_ready),
    .stall                        (stall),
    .trap_clear                   (trap_clear),
    .output_control_Branch        (br),
    .output_control_IoD           (iod),
    .output_control_IRWrite       (irw),
    .output_control_Mem2Reg       (m2r),
    .output_control_MemR          (memr),
    .output_control_MemW          (memw),
    .output_control_PCSrc         (pcsrc),
    .output_control_PCWrite       (pcw),
    .output_control_RegWrite      (regw),
    .output_control_ALUSrcA       (srca),
    .output_control_ALUSrcB       (srcb),
    .output_control_BranchType    (btype),
    .output_control_ALUOp         (aluop),
    .output_control_trap          (trap),
    .output_control_trap_cause    (cause),
    .output_control_instret       (instret),
    .output_control_current_state (st),
    .output_control_next_state    (nst)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic test_reset;
    Reset = 1'b1; input_control = '0; mem_ready = 1'b0; stall = 1'b0; trap_clear = 1'b0;
    tick(2);
    Reset = 1'b0; #1;
    n_checks++; if (st !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", st); end
    n_checks++; if (instret !== 4'd0) begin n_fail++; $display("FAIL reset_instret got %0d want 0", instret); end
    n_checks++; if (cause !== 2'b00) begin n_fail++; $display("FAIL reset_cause got %b want 00", cause); end
    n_checks++; if ({memr, iod, srca, srcb, aluop, irw, pcw, trap} !== {1'b1, 1'b0, 2'd0, 2'd1, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_fetch_outputs memr=%b iod=%b srca=%0d srcb=%0d aluop=%h irw=%b pcw=%b trap=%b",
                        memr, iod, srca, srcb, aluop, irw, pcw, trap);
    end
  endtask

  task automatic test_add;
    input_control = {4'b0000, 3'b000}; mem_ready = 1'b1; #1;
    n_checks++; if ({irw, pcw} !== 2'b11) begin n_fail++; $display("FAIL add_fetch_writes got %b want 11", {irw, pcw}); end
    n_checks++; if (nst !== 4'd1) begin n_fail++; $display("FAIL add_fetch_next got %0d want 1", nst); end
    tick(1);
    n_checks++; if ({st, aluop, memr} !== {4'd1, 4'hF, 1'b0}) begin
      n_fail++; $display("FAIL add_decode st=%0d aluop=%h memr=%b want 1 F 0", st, aluop, memr);
    end
    tick(1);
    n_checks++; if ({st, aluop, srca, srcb} !== {4'd2, 4'h0, 2'd2, 2'd0}) begin
      n_fail++; $display("FAIL add_rtype st=%0d aluop=%h srca=%0d srcb=%0d want 2 0 2 0", st, aluop, srca, srcb);
    end
    tick(1);
    n_checks++; if ({st, regw, m2r} !== {4'd4, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL add_rtype_end st=%0d regw=%b m2r=%b want 4 1 0", st, regw, m2r);
    end
    tick(1); exp_ir++;
    n_checks++; if ({st, instret} !== {4'd0, exp_ir}) begin
      n_fail++; $display("FAIL add_retire st=%0d instret=%0d want 0 %0d", st, instret, exp_ir);
    end
  endtask

  task automatic test_lw_wait;
    input_control = {4'b1001, 3'b010}; mem_ready = 1'b1;
    tick(2);
    n_checks++; if ({st, aluop, srcb} !== {4'd3, 4'h0, 2'd2}) begin
      n_fail++; $display("FAIL lw_ritype st=%0d aluop=%h srcb=%0d want 3 0 2", st, aluop, srcb);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_checks++; if ({st, memr, iod} !== {4'd5, 1'b1, 1'b1}) begin
        n_fail++; $display("FAIL lw1_wait%0d st=%0d memr=%b iod=%b want 5 1 1", i, st, memr, iod);
      end
    end
    mem_ready = 1'b1; #1;
    n_checks++; if ({st, memr, nst} !== {4'd5, 1'b1, 4'd6}) begin
      n_fail++; $display("FAIL lw1_ready st=%0d memr=%b nst=%0d want 5 1 6", st, memr, nst);
    end
    tick(1);
    n_checks++; if ({st, regw, m2r} !== {4'd6, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL lw2 st=%0d regw=%b m2r=%b want 6 1 1", st, regw, m2r);
    end
    tick(1); exp_ir++;
    n_checks++; if ({st, instret} !== {4'd0, exp_ir}) begin
      n_fail++; $display("FAIL lw_retire st=%0d instret=%0d want 0 %0d", st, instret, exp_ir);
    end
  endtask

  task automatic test_timeout;
    mem_ready = 1'b0; #1;
    n_checks++; if (irw !== 1'b0) begin n_fail++; $display("FAIL to_irwrite got %b want 0", irw); end
    for (int i = 0; i < 15; i++) begin
      tick(1);
      n_checks++; if (st !== 4'd0) begin n_fail++; $display("FAIL to_wait%0d st=%0d want 0", i, st); end
    end
    tick(1);
    n_checks++; if ({st, trap, cause} !== {4'd12, 1'b1, 2'b10}) begin
      n_fail++; $display("FAIL to_trap st=%0d trap=%b cause=%b want 12 1 10", st, trap, cause);
    end
    mem_ready = 1'b1; trap_clear = 1'b1;
    tick(1); trap_clear = 1'b0;
    n_checks++; if ({st, instret, cause} !== {4'd0, exp_ir, 2'b10}) begin
      n_fail++; $display("FAIL to_clear st=%0d instret=%0d cause=%b want 0 %0d 10", st, instret, cause, exp_ir);
    end
  endtask

  task automatic test_illegal;
    input_control = {4'b0000, 3'b110}; mem_ready = 1'b1;
    tick(2);
    n_checks++; if ({st, trap, cause} !== {4'd12, 1'b1, 2'b01}) begin
      n_fail++; $display("FAIL ill_trap st=%0d trap=%b cause=%b want 12 1 01", st, trap, cause);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1);
      n_checks++; if ({st, pcw, irw, regw, memw, aluop} !== {4'd12, 4'b0000, 4'hF}) begin
        n_fail++; $display("FAIL ill_hold%0d st=%0d en=%b aluop=%h want 12 0000 F", i, st, {pcw, irw, regw, memw}, aluop);
      end
    end
    trap_clear = 1'b1;
    tick(1); trap_clear = 1'b0;
    n_checks++; if ({st, instret} !== {4'd0, exp_ir}) begin
      n_fail++; $display("FAIL ill_clear st=%0d instret=%0d want 0 %0d", st, instret, exp_ir);
    end
  endtask

  task automatic test_branch_stall;
    input_control = {4'b1101, 3'b001}; mem_ready = 1'b1;
    tick(2);
    n_checks++; if ({st, aluop, br, btype, srcb} !== {4'd9, 4'h9, 1'b1, 2'b01, 2'd2}) begin
      n_fail++; $display("FAIL br_branch st=%0d aluop=%h br=%b bt=%b srcb=%0d want 9 9 1 01 2", st, aluop, br, btype, srcb);
    end
    tick(1);
    stall = 1'b1; #1;
    n_checks++; if ({st, pcw} !== {4'd10, 1'b0}) begin
      n_fail++; $display("FAIL br_stall0 st=%0d pcw=%b want 10 0", st, pcw);
    end
    for (int i = 1; i < 3; i++) begin
      tick(1);
      n_checks++; if ({st, pcw, instret} !== {4'd10, 1'b0, exp_ir}) begin
        n_fail++; $display("FAIL br_stall%0d st=%0d pcw=%b instret=%0d want 10 0 %0d", i, st, pcw, instret, exp_ir);
      end
    end
    stall = 1'b0; #1;
    n_checks++; if ({pcw, pcsrc, btype, aluop, srca} !== {1'b1, 1'b1, 2'b01, 4'h1, 2'd2}) begin
      n_fail++; $display("FAIL br_release pcw=%b pcsrc=%b bt=%b aluop=%h srca=%0d want 1 1 01 1 2", pcw, pcsrc, btype, aluop, srca);
    end
    tick(1); exp_ir++;
    n_checks++; if ({st, instret} !== {4'd0, exp_ir}) begin
      n_fail++; $display("FAIL br_retire st=%0d instret=%0d want 0 %0d", st, instret, exp_ir);
    end
  endtask

  task automatic test_back_to_back;
    input_control = {4'b1011, 3'b001}; mem_ready = 1'b1;
    tick(2);
    n_checks++; if ({st, srca, srcb, aluop, regw, pcw} !== {4'd8, 2'd3, 2'd1, 4'h7, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL jalr st=%0d srca=%0d srcb=%0d aluop=%h regw=%b pcw=%b want 8 3 1 7 1 0", st, srca, srcb, aluop, regw, pcw);
    end
    input_control = {4'b0000, 3'b100};
    tick(1); exp_ir++;
    n_checks++; if ({st, instret} !== {4'd0, exp_ir}) begin
      n_fail++; $display("FAIL jalr_retire st=%0d instret=%0d want 0 %0d", st, instret, exp_ir);
    end
    tick(2);
    n_checks++; if ({st, srca, aluop, regw, pcw} !== {4'd11, 2'd3, 4'h7, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL jal st=%0d srca=%0d aluop=%h regw=%b pcw=%b want 11 3 7 0 1", st, srca, aluop, regw, pcw);
    end
    tick(1); exp_ir++;
    n_checks++; if ({st, instret} !== {4'd0, exp_ir}) begin
      n_fail++; $display("FAIL jal_retire st=%0d instret=%0d want 0 %0d", st, instret, exp_ir);
    end
  endtask

  task automatic test_reset_mid_sw;
    input_control = {4'b1010, 3'b010}; mem_ready = 1'b1;
    tick(2);
    mem_ready = 1'b0;
    tick(1);
    n_checks++; if ({st, memw, iod} !== {4'd7, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL sw st=%0d memw=%b iod=%b want 7 1 1", st, memw, iod);
    end
    stall = 1'b1; #1;
    n_checks++; if ({memw, iod} !== 2'b01) begin
      n_fail++; $display("FAIL sw_stall memw=%b iod=%b want 0 1", memw, iod);
    end
    stall = 1'b0; Reset = 1'b1;
    tick(1);
    n_checks++; if ({st, memw, instret, cause} !== {4'd0, 1'b0, 4'd0, 2'b00}) begin
      n_fail++; $display("FAIL sw_reset st=%0d memw=%b instret=%0d cause=%b want 0 0 0 00", st, memw, instret, cause);
    end
    Reset = 1'b0; exp_ir = '0;
  endtask

  task automatic test_instret_wrap;
    input_control = {4'b0000, 3'b011}; mem_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick(2); exp_ir++;
      n_checks++; if ({st, instret} !== {4'd0, exp_ir}) begin
        n_fail++; $display("FAIL wrap%0d st=%0d instret=%0d want 0 %0d", i, st, instret, exp_ir);
      end
    end
    n_checks++; if (instret !== 4'd0) begin
      n_fail++; $display("FAIL wrap_final instret=%0d want 0", instret);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_lw_wait;
    test_timeout;
    test_illegal;
    test_branch_stall;
    test_back_to_back;
    test_reset_mid_sw;
    test_instret_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
